// File: rtl/para_loader.sv
// Streams 16-bit parameter words into the five weight-row banks and the bias RAM.
// Write strobes follow acceptance by one cycle. s_ready stays high through both load states.
`timescale 1ns/1ps
module para_loader #(
    parameter int W_WIDTH    = 15,
    parameter int B_WIDTH    = 15,
    parameter int KERNEL_NUM = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               s_valid,
    input  logic [15:0]        s_data,
    output logic               s_ready,
    output logic [4:0]         w_wr_en,
    output logic [7:0]         w_wr_addr,
    output logic [W_WIDTH:0]   w_wr_data,
    output logic               b_wr_en,
    output logic [4:0]         b_wr_addr,
    output logic [B_WIDTH:0]   b_wr_data,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, DONE} state_t;

    localparam logic [4:0] LAST_KERN = 5'(KERNEL_NUM - 1);

    state_t             state_q;
    logic [4:0]         kern_cnt_q;
    logic [2:0]         row_cnt_q;
    logic [2:0]         col_cnt_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic [4:0]         w_en_q;
    logic [7:0]         w_addr_q;
    logic [W_WIDTH:0]   w_data_q;
    logic               b_en_q;
    logic [4:0]         b_addr_q;
    logic [B_WIDTH:0]   b_data_q;
    logic [7:0]         w_addr_d;

    // Matches the read side: kernel*5 + col, computed as kernel*4 + kernel + col.
    assign w_addr_d = {1'b0, kern_cnt_q, 2'b00} + {3'b000, kern_cnt_q} + {5'b00000, col_cnt_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            kern_cnt_q <= '0;
            row_cnt_q  <= '0;
            col_cnt_q  <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            w_en_q     <= '0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            b_en_q     <= 1'b0;
            b_addr_q   <= '0;
            b_data_q   <= '0;
        end else begin
            w_en_q <= '0;
            b_en_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= LOAD_W;
                        kern_cnt_q <= '0;
                        row_cnt_q  <= '0;
                        col_cnt_q  <= '0;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD_W: begin
                    if (s_valid) begin
                        w_en_q   <= 5'b00001 << row_cnt_q;
                        w_addr_q <= w_addr_d;
                        w_data_q <= s_data[W_WIDTH:0];
                        if (col_cnt_q == 3'd4) begin
                            col_cnt_q <= '0;
                            row_cnt_q <= row_cnt_q + 3'd1;
                            if (row_cnt_q == 3'd4) begin
                                state_q <= LOAD_B;
                            end
                        end else begin
                            col_cnt_q <= col_cnt_q + 3'd1;
                        end
                    end
                end
                LOAD_B: begin
                    if (s_valid) begin
                        b_en_q     <= 1'b1;
                        b_addr_q   <= kern_cnt_q;
                        b_data_q   <= s_data[B_WIDTH:0];
                        kern_cnt_q <= kern_cnt_q + 5'd1;
                        row_cnt_q  <= '0;
                        col_cnt_q  <= '0;
                        if (kern_cnt_q == LAST_KERN) begin
                            // Final bias strobe and done land in the same cycle.
                            state_q <= DONE;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= LOAD_W;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready   = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign w_wr_en   = w_en_q;
    assign w_wr_addr = w_addr_q;
    assign w_wr_data = w_data_q;
    assign b_wr_en   = b_en_q;
    assign b_wr_addr = b_addr_q;
    assign b_wr_data = b_data_q;

endmodule

// File: tb/tb_para_loader.sv
// Scoreboarded bench for para_loader: a default instance (6 kernels) and a narrow one (1 kernel).
`timescale 1ns/1ps
module tb_para_loader;

    localparam int KN = 6;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, s_valid;
    logic [15:0] s_data;
    logic        s_ready, b_wr_en, busy, done;
    logic [4:0]  w_wr_en, b_wr_addr;
    logic [7:0]  w_wr_addr;
    logic [15:0] w_wr_data, b_wr_data;

    logic        start2, s_valid2;
    logic [15:0] s_data2;
    logic        s_ready2, b_wr_en2, busy2, done2;
    logic [4:0]  w_wr_en2, b_wr_addr2;
    logic [7:0]  w_wr_addr2;
    logic [7:0]  w_wr_data2;
    logic [11:0] b_wr_data2;

    para_loader #(.W_WIDTH(15), .B_WIDTH(15), .KERNEL_NUM(KN)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
        .busy(busy), .done(done)
    );

    para_loader #(.W_WIDTH(7), .B_WIDTH(11), .KERNEL_NUM(1)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .start(start2), .s_valid(s_valid2), .s_data(s_data2),
        .s_ready(s_ready2), .w_wr_en(w_wr_en2), .w_wr_addr(w_wr_addr2), .w_wr_data(w_wr_data2),
        .b_wr_en(b_wr_en2), .b_wr_addr(b_wr_addr2), .b_wr_data(b_wr_data2),
        .busy(busy2), .done(done2)
    );

    typedef struct {
        int          due;
        logic [4:0]  wen;
        logic [7:0]  waddr;
        logic [15:0] wdata;
        logic        ben;
        logic [4:0]  baddr;
        logic [15:0] bdata;
        logic        done;
    } item_t;

    item_t q0[$];
    item_t q1[$];
    item_t log0[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wcnt, bcnt, done_cnt, busy_err;
    int s_wcnt = 0, s_bcnt = 0;
    logic [7:0] s_last_waddr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic item_t mk(input int k, input int kn, input logic [15:0] wd,
                                 input logic [15:0] bd, input int due);
        item_t it;
        int kern;
        int r;
        it = '{default: 0};
        kern = k / 26;
        r = k % 26;
        it.due = due;
        if (r < 25) begin
            it.wen   = 5'(1 << (r / 5));
            it.waddr = 8'(kern * 5 + r % 5);
            it.wdata = wd;
        end else begin
            it.ben   = 1'b1;
            it.baddr = 5'(kern);
            it.bdata = bd;
        end
        it.done = (k == 26 * kn - 1);
        return it;
    endfunction

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cmp(input string nm, input item_t a, input item_t e);
        bit ok;
        if (e.ben)
            ok = (a.ben === 1'b1) && (a.wen === 5'b0) && (a.baddr === e.baddr) &&
                 (a.bdata === e.bdata) && (a.done === e.done);
        else
            ok = (a.ben === 1'b0) && (a.wen === e.wen) && (a.waddr === e.waddr) &&
                 (a.wdata === e.wdata) && (a.done === e.done);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cyc %0d got wen=%b waddr=%0d wdata=%h ben=%b baddr=%0d bdata=%h done=%b want wen=%b waddr=%0d wdata=%h ben=%b baddr=%0d bdata=%h done=%b",
                     nm, cyc, a.wen, a.waddr, a.wdata, a.ben, a.baddr, a.bdata, a.done,
                     e.wen, e.waddr, e.wdata, e.ben, e.baddr, e.bdata, e.done);
        end
    endtask

    // Monitor: pops the scoreboard whenever a write strobe is due or seen.
    always @(negedge clk) begin
        item_t a;
        bit    stb;
        a = '{default: 0};
        a.due = cyc; a.wen = w_wr_en; a.waddr = w_wr_addr; a.wdata = w_wr_data;
        a.ben = b_wr_en; a.baddr = b_wr_addr; a.bdata = b_wr_data; a.done = done;
        stb = (|a.wen) || a.ben;
        if (done === 1'b1) done_cnt++;
        if ((|a.wen) && a.ben) fail("main_two_strobes");
        if (a.done && !a.ben) fail("main_done_without_bias");
        if (stb) begin
            log0.push_back(a);
            if (a.ben) bcnt++; else wcnt++;
        end
        while (q0.size() > 0 && q0[0].due < cyc) begin
            fail("main_missed_write");
            void'(q0.pop_front());
        end
        if (q0.size() > 0 && q0[0].due == cyc) begin
            if (!stb) fail("main_missing_strobe");
            else cmp("main_write", a, q0[0]);
            void'(q0.pop_front());
        end else if (stb) begin
            fail("main_unexpected_strobe");
        end

        a = '{default: 0};
        a.due = cyc; a.wen = w_wr_en2; a.waddr = w_wr_addr2; a.wdata = 16'(w_wr_data2);
        a.ben = b_wr_en2; a.baddr = b_wr_addr2; a.bdata = 16'(b_wr_data2); a.done = done2;
        stb = (|a.wen) || a.ben;
        if ((|a.wen) && a.ben) fail("small_two_strobes");
        if (a.done && !a.ben) fail("small_done_without_bias");
        if (|a.wen) begin s_wcnt++; s_last_waddr = a.waddr; end
        if (a.ben) s_bcnt++;
        while (q1.size() > 0 && q1[0].due < cyc) begin
            fail("small_missed_write");
            void'(q1.pop_front());
        end
        if (q1.size() > 0 && q1[0].due == cyc) begin
            if (!stb) fail("small_missing_strobe");
            else cmp("small_write", a, q1[0]);
            void'(q1.pop_front());
        end else if (stb) begin
            fail("small_unexpected_strobe");
        end
    end

    // Drives n words (data = word index); pulse_at < 0 disables the mid-load start pulse.
    task automatic load(input int n, input bit rnd, input bit same, input int pulse_at);
        int  k;
        int  guard;
        bit  v;
        start = 1'b1;
        if (same) begin s_valid = 1'b1; s_data = 16'hBEEF; end
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        guard = 0;
        while (k < n && guard < 5000) begin
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_valid = v;
            s_data  = v ? 16'(k) : 16'hDEAD;
            start   = v && (k == pulse_at);
            if (v) begin
                q0.push_back(mk(k, KN, 16'(k), 16'(k), cyc + 1));
                k++;
            end
            @(posedge clk); #1;
            if (k < 26 * KN && busy !== 1'b1) busy_err++;
            guard++;
        end
        if (k < n) fail("load_timeout");
        start = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic clear_stats();
        log0.delete();
        wcnt = 0; bcnt = 0; busy_err = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
        start2 = 1'b0; s_valid2 = 1'b0; s_data2 = '0;
        done_cnt = 0;
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {s_ready, w_wr_en, w_wr_addr, w_wr_data, b_wr_en, b_wr_addr, b_wr_data, busy, done}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: continuous load
        clear_stats();
        load(156, 1'b0, 1'b0, -1);
        chk("s1_done_in_done_state", done, 1'b1);
        chk("s1_busy_low_in_done", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("s1_log_size", log0.size(), 156);
        if (log0.size() == 156) begin
            chk("s1_w0", {log0[0].wen, log0[0].waddr, log0[0].wdata}, {5'b00001, 8'd0, 16'd0});
            chk("s1_w7", {log0[7].wen, log0[7].waddr}, {5'b00010, 8'd2});
            chk("s1_b25", {log0[25].ben, log0[25].baddr, log0[25].bdata}, {1'b1, 5'd0, 16'd25});
            chk("s1_w26", {log0[26].wen, log0[26].waddr}, {5'b00001, 8'd5});
            chk("s1_b155", {log0[155].ben, log0[155].baddr, log0[155].done}, {1'b1, 5'd5, 1'b1});
        end
        chk("s1_weight_strobes", wcnt, 150);
        chk("s1_bias_strobes", bcnt, 6);
        chk("s1_busy_held", busy_err, 0);

        // 2: random valid gaps
        clear_stats();
        load(156, 1'b1, 1'b0, -1);
        repeat (2) @(posedge clk);
        #1;
        chk("s2_busy_held", busy_err, 0);
        chk("s2_weight_strobes", wcnt, 150);
        chk("s2_bias_strobes", bcnt, 6);

        // 3: words offered outside the load states are refused
        s_valid = 1'b1; s_data = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1;
        chk("s3_ready_idle", s_ready, 1'b0);
        clear_stats();
        load(156, 1'b0, 1'b1, -1);
        s_valid = 1'b1; s_data = 16'hBEEF;
        chk("s3_ready_in_done", s_ready, 1'b0);
        @(posedge clk); #1;
        chk("s3_ready_after_done", s_ready, 1'b0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(posedge clk); #1;
        chk("s3_log_size", log0.size(), 156);
        if (log0.size() > 0)
            chk("s3_first_write", {log0[0].wen, log0[0].waddr, log0[0].wdata}, {5'b00001, 8'd0, 16'd0});

        // 4: start pulse mid-load is ignored
        clear_stats();
        load(156, 1'b0, 1'b0, 40);
        repeat (2) @(posedge clk);
        #1;
        chk("s4_log_size", log0.size(), 156);
        if (log0.size() == 156)
            chk("s4_w40", {log0[40].wen, log0[40].waddr, log0[40].wdata}, {5'b00100, 8'd9, 16'd40});
        chk("s4_bias_strobes", bcnt, 6);

        // 5: reset mid-load
        clear_stats();
        load(61, 1'b0, 1'b0, -1);
        done_cnt = 0;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("s5_async_zero", {s_ready, w_wr_en, w_wr_addr, w_wr_data, b_wr_en, b_wr_addr, b_wr_data, busy, done}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("s5_no_done", done_cnt, 0);
        chk("s5_queue_empty", q0.size(), 0);
        clear_stats();
        load(156, 1'b0, 1'b0, -1);
        repeat (2) @(posedge clk);
        #1;
        if (log0.size() > 0)
            chk("s5_restart_w0", {log0[0].wen, log0[0].waddr}, {5'b00001, 8'd0});
        chk("s5_restart_bias", bcnt, 6);

        // 6: narrow widths, single kernel
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int k = 0; k < 26; k++) begin
            s_valid2 = 1'b1;
            s_data2  = 16'hA5C3;
            q1.push_back(mk(k, 1, 16'h00C3, 16'h05C3, cyc + 1));
            @(posedge clk); #1;
        end
        s_valid2 = 1'b0;
        chk("s6_done", done2, 1'b1);
        chk("s6_bias_data", b_wr_data2, 12'h5C3);
        repeat (2) @(posedge clk);
        #1;
        chk("s6_weight_strobes", s_wcnt, 25);
        chk("s6_bias_strobes", s_bcnt, 1);
        chk("s6_last_waddr", s_last_waddr, 8'd4);
        chk("s6_weight_data", w_wr_data2, 8'hC3);

        repeat (2) @(posedge clk);
        #1;
        chk("final_q0_empty", q0.size(), 0);
        chk("final_q1_empty", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
